dich_xuat: RTL
==============

// Module: dich_xuat
// PURPOSE
//   Parallel-in/serial-out transmitter: the sending end of the serial LED shift chain.
//   Accepts a WIDTH-bit word via a load/ready handshake and shifts it out on dout, one bit per
//   shift tick. An internal tick generator derives the bit rate from CLK; no derived clocks.
//   Sits beside the clock divider/serial shift-in pair; its dout drives their din.
// PARAMETERS
//   CLK_HZ     50_000_000  input clock frequency (Hz)
//   SHIFT_HZ   1           bit rate; DIV = CLK_HZ/SHIFT_HZ; DIV >= 2 required
//   WIDTH      8           word width (bits), >= 2
//   MSB_FIRST  1           1: send bit WIDTH-1 first; 0: send bit 0 first
//   IDLE_LVL   1'b0        dout level outside a frame
// PORTS
//   CLK    in   1      system clock, all logic on rising edge
//   rs     in   1      reset, asynchronous, active-low
//   din    in   WIDTH  parallel word, sampled only on accept
//   load   in   1      request to send din
//   ready  out  1      1 = idle, a load is accepted this cycle
//   dout   out  1      serial data out
//   tick   out  1      1-cycle strobe marking each bit boundary (for a receiver clock enable)
//   busy   out  1      1 while a frame is in progress
//   done   out  1      1-cycle pulse after the last bit period ends
//   led    out  WIDTH  last accepted word (display)
// BEHAVIOUR
//   Reset (rs=0, async): state=IDLE, ready=1, dout=IDLE_LVL, tick=0, busy=0, done=0, led=0,
//     sreg=0, bitcnt=0, divcnt=0. Reset mid-frame aborts at once; the partial frame is not resumed.
//   FSM states IDLE, SHIFT, DONE (encoded 2 bits).
//   IDLE: ready=1. Accept = load&ready at a rising edge: sreg<=din, led<=din, bitcnt<=0,
//     divcnt<=0, -> SHIFT. The first data bit is on dout from the cycle after the accept.
//   SHIFT: ready=0, busy=1. divcnt counts 0..DIV-1; tick=1 for the one cycle divcnt==DIV-1,
//     then divcnt wraps to 0. On a tick: if bitcnt==WIDTH-1 -> DONE; otherwise shift sreg
//     (left if MSB_FIRST, else right, fill 0), bitcnt++.
//   dout is registered: in SHIFT it is sreg[WIDTH-1] (MSB_FIRST) or sreg[0]. Each bit holds for
//     exactly DIV cycles. Frame = WIDTH*DIV cycles from the cycle after accept to entry to DONE.
//   DONE: lasts 1 cycle. done=1, busy=0, dout=IDLE_LVL, ready=0, then -> IDLE.
//     Minimum accept-to-accept spacing is WIDTH*DIV+2 cycles.
//   load while busy/DONE: ignored, no queuing; din changes mid-frame have no effect.
//   load held high: a new frame is accepted on the first IDLE cycle (back-to-back frames).
//   tick is 0 outside SHIFT; divcnt is held at 0 in IDLE/DONE.
//   Width rules: divcnt is $clog2(DIV) bits, bitcnt is $clog2(WIDTH) bits; no truncation of DIV.
// STRUCTURE
//   Shared package/header: FSM state localparams (ST_IDLE, ST_SHIFT, ST_DONE) and the DIV
//     computation, so the matching receive side uses the same encoding and rate.
//   One sub-module: dich_tick (parameter DIV; ports CLK, rs, clr, en, tick) — enable-strobe
//     counter that replaces the derived-clock divider. The FSM and shift register stay in
//     dich_xuat.
// TESTING  (sim: CLK_HZ=8, SHIFT_HZ=2 -> DIV=4, WIDTH=8)
//   1 Reset: rs=0 mid-run -> ready=1, busy=0, dout=0, led=0 immediately (no clock edge needed).
//   2 load=1 for 1 cycle with din=8'hA5, MSB_FIRST=1 -> dout = 1,0,1,0,0,1,0,1, each bit 4
//     cycles; 8 ticks; done pulses at cycle 33 after accept; led=8'hA5.
//   3 MSB_FIRST=0, din=8'h01 -> dout=1 for the first 4 cycles, then 0 for 28 cycles; done once.
//   4 load pulsed and din=8'hFF during the frame of 8'h3C -> ignored; output stays 8'h3C pattern.
//   5 load held high, din=8'h81 then 8'h7E -> two back-to-back frames, accepts 34 cycles apart.
//   6 rs=0 at bit 3 of 8'hF0, then release and load 8'h0F -> clean 8'h0F frame, bitcnt restarts at 0.

Source files
------------

// File: rtl/dich_xuat_pkg.sv
// Shared definitions for the serial LED shift chain: FSM encoding and bit-rate divider math.
// The receive side imports this package too, so both ends use the same encoding and rate.
package dich_xuat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int calc_div(input longint clk_hz, input longint shift_hz);
    return int'(clk_hz / shift_hz);
  endfunction

endpackage

// File: rtl/dich_tick.sv
// Enable-strobe counter: produces a one-cycle tick every DIV enabled cycles.
// It stands in for a derived clock, so everything stays on CLK.
module dich_tick #(
  parameter int DIV = 4
) (
  input  logic CLK,
  input  logic rs,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] divcnt;

  always_ff @(posedge CLK or negedge rs) begin
    if (!rs) begin
      divcnt <= '0;
    end else if (clr) begin
      divcnt <= '0;
    end else if (en) begin
      divcnt <= (divcnt == LAST) ? '0 : divcnt + 1'b1;
    end
  end

  assign tick = en && (divcnt == LAST);

endmodule

// File: rtl/dich_xuat.sv
// Parallel-in/serial-out transmitter for the LED shift chain.
// It accepts a word on load&ready and sends it on dout, one bit per tick.
module dich_xuat
  import dich_xuat_pkg::*;
#(
  parameter int   CLK_HZ    = 50_000_000,
  parameter int   SHIFT_HZ  = 1,
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_LVL  = 1'b0
) (
  input  logic             CLK,
  input  logic             rs,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             dout,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] led
);

  localparam int DIV = calc_div(CLK_HZ, SHIFT_HZ);
  localparam int BW  = $clog2(WIDTH);
  localparam logic [BW-1:0] LASTBIT = BW'(WIDTH - 1);

  state_t           state, nextState;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]    bitcnt;
  logic             accept;
  logic             lastTick;
  logic             tickEn;
  logic             tickClr;

  // Enable and clear come straight from the state register to keep the tick path acyclic.
  assign tickEn  = (state == ST_SHIFT);
  assign tickClr = (state != ST_SHIFT);

  dich_tick #(.DIV(DIV)) u_tick (
    .CLK  (CLK),
    .rs   (rs),
    .clr  (tickClr),
    .en   (tickEn),
    .tick (tick)
  );

  always_ff @(posedge CLK or negedge rs) begin
    if (!rs) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    lastTick  = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (load) begin
          accept    = 1'b1;
          nextState = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (tick && (bitcnt == LASTBIT)) begin
          lastTick  = 1'b1;
          nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // dout is loaded with the bit that will be at the sreg output edge after this clock.
  always_ff @(posedge CLK or negedge rs) begin
    if (!rs) begin
      sreg   <= '0;
      bitcnt <= '0;
      led    <= '0;
      dout   <= IDLE_LVL;
    end else if (accept) begin
      sreg   <= din;
      led    <= din;
      bitcnt <= '0;
      dout   <= MSB_FIRST ? din[WIDTH-1] : din[0];
    end else if (lastTick) begin
      dout <= IDLE_LVL;
    end else if ((state == ST_SHIFT) && tick) begin
      sreg   <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
      bitcnt <= bitcnt + 1'b1;
      dout   <= MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
    end
  end

endmodule
